// File: rtl/dequantizer_pipe.sv
// Two-stage int8 -> ACC_WIDTH dequantizer: (q - zp) * scale with round-half-up and saturation.
// Stage 1 registers the zero-point difference and a scale snapshot. Stage 2 registers the result.
module dequantizer_pipe #(
  parameter int unsigned LANES       = 4,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned M0_WIDTH    = 32,
  parameter int unsigned FIXED_SHIFT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [M0_WIDTH-1:0]        cfg_scale,
  input  logic [7:0]                 cfg_zp,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*8-1:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ACC_WIDTH-1:0] out_data,
  output logic [LANES-1:0]           out_sat,
  output logic [15:0]                sat_count
);

  localparam int unsigned PW = M0_WIDTH + 9;
  localparam int unsigned DW = LANES * 9;
  localparam logic [M0_WIDTH-1:0]  SCALE_ONE = M0_WIDTH'(1) << FIXED_SHIFT;
  localparam logic signed [PW-1:0] RND       = PW'(1) << (FIXED_SHIFT - 1);
  localparam logic signed [PW-1:0] ACC_MAX   = (PW'(1) << (ACC_WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] ACC_MIN   = -ACC_MAX - PW'(1);

  logic [M0_WIDTH-1:0]        scale_q, scale_d;
  logic [7:0]                 zp_q, zp_d;
  logic                       s1_valid_q, s1_valid_d;
  logic [DW-1:0]              s1_diff_q, s1_diff_d;
  logic [M0_WIDTH-1:0]        s1_scale_q, s1_scale_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [LANES*ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]           out_sat_q, out_sat_d;
  logic [15:0]                sat_count_q, sat_count_d;

  logic                       s2_adv_c;
  logic [LANES*ACC_WIDTH-1:0] res_c;
  logic [LANES-1:0]           sat_c;
  logic [16:0]                pop_c;
  logic [16:0]                sum_c;

  assign s2_adv_c  = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv_c;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

  // Per-lane multiply, round half up, arithmetic shift and clip
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] shf;
    logic                 hi;
    logic                 lo;
    assign prod = PW'($signed(s1_diff_q[9*g +: 9])) * PW'($signed(s1_scale_q));
    assign rnd  = prod + RND;
    assign shf  = rnd >>> FIXED_SHIFT;
    assign hi   = shf > ACC_MAX;
    assign lo   = shf < ACC_MIN;
    assign res_c[ACC_WIDTH*g +: ACC_WIDTH] = hi ? ACC_WIDTH'(ACC_MAX) :
                                             lo ? ACC_WIDTH'(ACC_MIN) : ACC_WIDTH'(shf);
    assign sat_c[g] = hi || lo;
  end

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_c = pop_c + 17'(out_sat_q[i]);
    end
    sum_c = 17'(sat_count_q) + pop_c;
  end

  always_comb begin
    scale_d     = scale_q;
    zp_d        = zp_q;
    s1_valid_d  = s1_valid_q;
    s1_diff_d   = s1_diff_q;
    s1_scale_d  = s1_scale_q;
    s2_valid_d  = s2_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    sat_count_d = sat_count_q;

    if (cfg_we) begin
      scale_d = cfg_scale;
      zp_d    = cfg_zp;
    end

    // Accepted beats capture the pre-update config
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_scale_d = scale_q;
        for (int i = 0; i < LANES; i++) begin
          s1_diff_d[9*i +: 9] = {in_data[8*i+7], in_data[8*i +: 8]} - {zp_q[7], zp_q};
        end
      end
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = res_c;
        out_sat_d  = sat_c;
      end
    end

    if (s2_valid_q && out_ready) begin
      sat_count_d = sum_c[16] ? 16'hFFFF : sum_c[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scale_q     <= SCALE_ONE;
      zp_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_diff_q   <= '0;
      s1_scale_q  <= '0;
      s2_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      sat_count_q <= '0;
    end else begin
      scale_q     <= scale_d;
      zp_q        <= zp_d;
      s1_valid_q  <= s1_valid_d;
      s1_diff_q   <= s1_diff_d;
      s1_scale_q  <= s1_scale_d;
      s2_valid_q  <= s2_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule

// File: tb/tb_dequantizer_pipe.sv
// Bench for dequantizer_pipe: two instances (ACC_WIDTH 32 and 16) share stimulus and are
// scored against an arithmetic model of the dequantization rules.
module tb_dequantizer_pipe;

  logic         clk;
  logic         rst;
  logic         cfg_we;
  logic [31:0]  cfg_scale;
  logic [7:0]   cfg_zp;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         out_ready;
  logic         in_ready, in_ready16;
  logic         out_valid, out_valid16;
  logic [127:0] out_data;
  logic [63:0]  out_data16;
  logic [3:0]   out_sat, out_sat16;
  logic [15:0]  sat_count, sat_count16;

  dequantizer_pipe dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_scale(cfg_scale), .cfg_zp(cfg_zp),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .sat_count(sat_count)
  );

  dequantizer_pipe #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_scale(cfg_scale), .cfg_zp(cfg_zp),
    .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_sat(out_sat16), .sat_count(sat_count16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   s;
  } exp_t;

  typedef struct {
    logic [31:0]  scale;
    logic [7:0]   zp;
    logic [31:0]  din;
    logic [127:0] e32;
    logic [3:0]   es32;
    logic [63:0]  e16;
    logic [3:0]   es16;
  } vec_t;

  exp_t        q32[$];
  exp_t        q16[$];
  vec_t        vt[6];
  logic [31:0] m_scale;
  logic [7:0]  m_zp;
  int          m_cnt32, m_cnt16;
  int          total, bad;
  logic        acc_flag;
  int          accepted;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Plain integer evaluation of (q - zp) * scale / 2^16, rounded half up, clipped per width
  task automatic model(input logic [31:0] din, input logic [7:0] zp, input logic [31:0] sc,
                       output logic [127:0] d32, output logic [3:0] s32,
                       output logic [63:0] d16, output logic [3:0] s16);
    longint q, z, s, r, v;
    logic [7:0] lb;
    z = longint'($signed(zp));
    s = longint'($signed(sc));
    d32 = '0; d16 = '0; s32 = '0; s16 = '0;
    for (int i = 0; i < 4; i++) begin
      lb = din[8*i +: 8];
      q  = longint'($signed(lb));
      r  = ((q - z) * s + 64'sd32768) >>> 16;
      v = r;
      if (r > 64'sd2147483647) begin v = 64'sd2147483647; s32[i] = 1'b1; end
      if (r < -64'sd2147483648) begin v = -64'sd2147483648; s32[i] = 1'b1; end
      d32[32*i +: 32] = 32'(v);
      v = r;
      if (r > 64'sd32767) begin v = 64'sd32767; s16[i] = 1'b1; end
      if (r < -64'sd32768) begin v = -64'sd32768; s16[i] = 1'b1; end
      d16[16*i +: 16] = 16'(v);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  // One clock: score outputs against the model, track accepts, advance to the next negedge
  task automatic step();
    logic [127:0] d32;
    logic [63:0]  d16;
    logic [3:0]   s32, s16;
    exp_t         e;
    #1;
    acc_flag = in_valid && in_ready;
    if (out_valid) begin
      if (q32.size() == 0) chk("spurious_ov32", 128'(out_valid), 128'(0));
      else begin
        chk("data32", out_data, q32[0].d);
        chk("sat32", 128'(out_sat), 128'(q32[0].s));
        if (out_ready) begin
          m_cnt32 = sat_add(m_cnt32, $countones(q32[0].s));
          q32.delete(0);
        end
      end
    end
    if (out_valid16) begin
      if (q16.size() == 0) chk("spurious_ov16", 128'(out_valid16), 128'(0));
      else begin
        chk("data16", 128'(out_data16), q16[0].d);
        chk("sat16", 128'(out_sat16), 128'(q16[0].s));
        if (out_ready) begin
          m_cnt16 = sat_add(m_cnt16, $countones(q16[0].s));
          q16.delete(0);
        end
      end
    end
    model(in_data, m_zp, m_scale, d32, s32, d16, s16);
    if (in_valid && in_ready) begin
      e.d = d32; e.s = s32; q32.push_back(e);
      accepted++;
    end
    if (in_valid && in_ready16) begin
      e.d = 128'(d16); e.s = s16; q16.push_back(e);
    end
    if (cfg_we) begin
      m_scale = cfg_scale;
      m_zp    = cfg_zp;
    end
    @(posedge clk);
    @(negedge clk);
    chk("sat_count32", 128'(sat_count), 128'(m_cnt32));
    chk("sat_count16", 128'(sat_count16), 128'(m_cnt16));
  endtask

  task automatic set_cfg(input logic [31:0] sc, input logic [7:0] zp);
    in_valid  = 1'b0;
    cfg_we    = 1'b1;
    cfg_scale = sc;
    cfg_zp    = zp;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && (q32.size() > 0 || q16.size() > 0); i++) step();
    chk("drain_empty32", 128'(q32.size()), 128'(0));
    chk("drain_empty16", 128'(q16.size()), 128'(0));
  endtask

  task automatic model_reset();
    q32.delete();
    q16.delete();
    m_scale = 32'h0001_0000;
    m_zp    = 8'h00;
    m_cnt32 = 0;
    m_cnt16 = 0;
  endtask

  initial begin
    total = 0; bad = 0; accepted = 0; acc_flag = 1'b0;
    rst = 1'b1; cfg_we = 1'b0; cfg_scale = '0; cfg_zp = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();

    vt[0] = '{32'h0001_0000, 8'h00, 32'h7F00FF80,
              128'h0000007F_00000000_FFFFFFFF_FFFFFF80, 4'h0, 64'h007F_0000_FFFF_FF80, 4'h0};
    vt[1] = '{32'h0000_8000, 8'h00, 32'hFF01FD03,
              128'h00000000_00000001_FFFFFFFF_00000002, 4'h0, 64'h0000_0001_FFFF_0002, 4'h0};
    vt[2] = '{32'h0001_0000, 8'h80, 32'hFF80007F,
              128'h0000007F_00000000_00000080_000000FF, 4'h0, 64'h007F_0000_0080_00FF, 4'h0};
    vt[3] = '{32'h0001_0000, 8'h7F, 32'h01007F80,
              128'hFFFFFF82_FFFFFF81_00000000_FFFFFF01, 4'h0, 64'hFF82_FF81_0000_FF01, 4'h0};
    vt[4] = '{32'h7FFF_FFFF, 8'h80, 32'h8080807F,
              128'h00000000_00000000_00000000_007F8000, 4'h0, 64'h0000_0000_0000_7FFF, 4'h1};
    vt[5] = '{32'h7FFF_FFFF, 8'h7F, 32'h7F7F7F80,
              128'h00000000_00000000_00000000_FF808000, 4'h0, 64'h0000_0000_0000_8000, 4'h1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'({out_valid, out_valid16}), 128'(0));
    chk("rst_out_data", out_data | 128'(out_data16), 128'(0));
    chk("rst_out_sat", 128'({out_sat, out_sat16}), 128'(0));
    chk("rst_sat_count", 128'({sat_count, sat_count16}), 128'(0));
    chk("rst_in_ready", 128'({in_ready, in_ready16}), 128'(2'b11));
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors with two-cycle latency check
    for (int v = 0; v < 6; v++) begin
      set_cfg(vt[v].scale, vt[v].zp);
      out_ready = 1'b1;
      in_data   = vt[v].din;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_lat1", v), 128'({out_valid, out_valid16}), 128'(0));
      step();
      chk($sformatf("v%0d_lat2", v), 128'({out_valid, out_valid16}), 128'(2'b11));
      chk($sformatf("v%0d_d32", v), out_data, vt[v].e32);
      chk($sformatf("v%0d_s32", v), 128'(out_sat), 128'(vt[v].es32));
      chk($sformatf("v%0d_d16", v), 128'(out_data16), 128'(vt[v].e16));
      chk($sformatf("v%0d_s16", v), 128'(out_sat16), 128'(vt[v].es16));
      step();
    end
    chk("tbl_satcnt16", 128'(sat_count16), 128'(2));
    chk("tbl_satcnt32", 128'(sat_count), 128'(0));

    // Random stream of 20 beats with random backpressure and mid-stream config writes
    accepted = 0;
    acc_flag = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 600 && accepted < 20; c++) begin
      if (!in_valid || acc_flag) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out_ready = 1'($urandom_range(0, 1));
      cfg_we    = (c == 7) || (c == 19);
      cfg_scale = $urandom;
      cfg_zp    = 8'($urandom);
      step();
    end
    cfg_we = 1'b0;
    chk("rand_accepted", 128'(accepted), 128'(20));
    drain();

    // Full throughput with out_ready held high
    set_cfg(32'h0001_8000, 8'hF0);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      step();
      chk($sformatf("thru_acc%0d", i), 128'(acc_flag), 128'(1));
      if (i >= 1) chk($sformatf("thru_ov%0d", i), 128'(out_valid), 128'(1));
    end
    drain();

    // Reset with two beats in flight
    set_cfg(32'h0002_0000, 8'h05);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11223344;
    step();
    in_data = 32'h55667788;
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", 128'({out_valid, out_valid16}), 128'(0));
    chk("mid_rst_cnt", 128'({sat_count, sat_count16}), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h05FB7F80;
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_ov", 128'(out_valid), 128'(1));
    chk("post_rst_d32", out_data, 128'h00000005_FFFFFFFB_0000007F_FFFFFF80);
    step();
    drain();

    // sat_count saturation: every lane clips on the 16-bit instance
    set_cfg(32'h7FFF_FFFF, 8'h80);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h7F7F7F7F;
    repeat (16390) step();
    drain();
    chk("satcnt16_max", 128'(sat_count16), 128'(16'hFFFF));
    chk("satcnt32_none", 128'(sat_count), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
